// File: rtl/fpga_cfg_loader_pkg.sv
// Shared types, constants and the byte-wise CRC-8 step for the config loader
// and anything else that needs to reproduce its frame check.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CHECK,
        LATCH
    } state_e;

    localparam logic [7:0] CRC8_POLY         = 8'h07;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // CRC-8, poly 0x07, MSB-first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Byte handshake between the pin wrapper (master) and the config loader (slave).
interface fpga_cfg_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/fpga_cfg_loader_crc8.sv
// Registered CRC-8 accumulator; clear wins over enable so a new frame always starts from zero.
module cfg_crc8
    import fpga_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 8'h00;
        end else if (en_i) begin
            crc_d = crc8_next(crc_q, data_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Frame parser and serialiser: sync byte, CHAIN_LEN/8 data bytes shifted MSB-first
// into the fabric chain, then a CRC byte that decides whether the chain is latched.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int         CHAIN_LEN = 256,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    fpga_cfg_loader_if.slave   host,
    output logic               cfg_data,
    output logic               cfg_shift_en,
    output logic               cfg_latch,
    output logic               busy,
    output logic               done,
    output logic               crc_err
);

    localparam int                NBYTES   = CHAIN_LEN / 8;
    localparam int                CNT_W    = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NBYTES);

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             done_q, done_d;
    logic             crc_err_q, crc_err_d;
    logic             crc_clr;
    logic             crc_en;
    logic [7:0]       crc_val;

    cfg_crc8 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .data_i (host.byte_in),
        .crc_o  (crc_val)
    );

    // byte_ready depends only on state, so transfers are qualified by byte_valid
    // alone inside each ready state to keep the handshake free of comb loops.
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        shreg_d         = shreg_q;
        done_d          = done_q;
        crc_err_d       = crc_err_q;
        crc_clr         = 1'b0;
        crc_en          = 1'b0;
        host.byte_ready = 1'b0;
        cfg_data        = 1'b0;
        cfg_shift_en    = 1'b0;
        cfg_latch       = 1'b0;

        case (state_q)
            IDLE: begin
                host.byte_ready = 1'b1;
                if (host.byte_valid && (host.byte_in == SYNC_BYTE)) begin
                    state_d    = LOAD;
                    crc_clr    = 1'b1;
                    byte_cnt_d = '0;
                    done_d     = 1'b0;
                    crc_err_d  = 1'b0;
                end
            end
            LOAD: begin
                host.byte_ready = 1'b1;
                if (host.byte_valid) begin
                    shreg_d    = host.byte_in;
                    crc_en     = 1'b1;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    bit_cnt_d  = 3'd0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                cfg_shift_en = 1'b1;
                cfg_data     = shreg_q[7];
                shreg_d      = {shreg_q[6:0], 1'b0};
                bit_cnt_d    = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = (byte_cnt_q == LAST_CNT) ? CHECK : LOAD;
                end
            end
            CHECK: begin
                host.byte_ready = 1'b1;
                if (host.byte_valid) begin
                    if (host.byte_in == crc_val) begin
                        state_d = LATCH;
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            LATCH: begin
                cfg_latch = 1'b1;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            shreg_q    <= 8'h00;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign crc_err = crc_err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader: a frame-level reference model predicts handshake,
// status flags and the expected serial/latch events, and a negedge monitor checks the chain side.
module tb_fpga_cfg_loader;

    localparam int         CHAIN_LEN = 16;
    localparam int         NB        = CHAIN_LEN / 8;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam int         INF       = 1 << 30;

    logic clk = 1'b0;
    logic rst;
    logic cfg_data, cfg_shift_en, cfg_latch, busy, done, crc_err;

    fpga_cfg_loader_if host();

    fpga_cfg_loader #(.CHAIN_LEN(CHAIN_LEN), .SYNC_BYTE(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (host),
        .cfg_data     (cfg_data),
        .cfg_shift_en (cfg_shift_en),
        .cfg_latch    (cfg_latch),
        .busy         (busy),
        .done         (done),
        .crc_err      (crc_err)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; cycle k+1 lies between edge k and edge k+1
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit   is_latch;
        logic val;
        int   cyc;
    } ev_t;
    ev_t evq[$];

    // Frame-level reference model state
    bit         in_frame;
    int         n_data;
    logic [7:0] msg[$];
    int         blocked_until;
    int         done_at;
    int         err_at;
    bit         mon_en = 1'b0;
    bit         es, el;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1
    function automatic logic [7:0] ref_crc(input logic [7:0] m[$]);
        logic [8:0] r;
        r = 9'h000;
        for (int j = 0; j < m.size() + 1; j++) begin
            for (int i = 7; i >= 0; i--) begin
                r = {r[7:0], (j < m.size()) ? m[j][i] : 1'b0};
                if (r[8]) r = r ^ 9'h107;
            end
        end
        return r[7:0];
    endfunction

    task automatic model_reset();
        in_frame      = 1'b0;
        n_data        = 0;
        msg.delete();
        blocked_until = 0;
        done_at       = INF;
        err_at        = INF;
    endtask

    // Byte accepted on edge n
    task automatic accept(input logic [7:0] b, input int n);
        if (!in_frame) begin
            if (b == SYNC) begin
                in_frame = 1'b1;
                n_data   = 0;
                msg.delete();
                done_at  = INF;
                err_at   = INF;
            end
        end else if (n_data < NB) begin
            msg.push_back(b);
            n_data++;
            for (int i = 7; i >= 0; i--) evq.push_back('{1'b0, b[i], n + 7 - i});
            blocked_until = n + 8;
        end else begin
            if (b == ref_crc(msg)) begin
                evq.push_back('{1'b1, 1'b1, n});
                done_at       = n + 1;
                blocked_until = n + 1;
            end else begin
                err_at = n;
            end
            in_frame = 1'b0;
        end
    endtask

    // Called at posedge+1; checks the coming cycle and drives the next edge
    task automatic tick(input logic v, input logic [7:0] b);
        bit rdy;
        host.byte_valid = v;
        host.byte_in    = b;
        rdy = (cyc >= blocked_until);
        check("byte_ready", host.byte_ready, rdy);
        check("busy", busy, in_frame || !rdy);
        check("done", done, cyc >= done_at);
        check("crc_err", crc_err, cyc >= err_at);
        if (v && rdy) accept(b, cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit r;
        int guard;
        guard = 0;
        while (1) begin
            r = (cyc >= blocked_until);
            tick(1'b1, b);
            if (r) break;
            guard++;
            if (guard > 50) begin
                check("send_byte timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic send_gap(input logic [7:0] b);
        idle($urandom_range(0, 2));
        send_byte(b);
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        host.byte_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        evq.delete();
    endtask

    task automatic bp_frame();
        logic [7:0] b;
        bit started;
        started = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!in_frame)          b = SYNC;
            else if (n_data == NB)  b = ref_crc(msg);
            else                    b = 8'($urandom);
            tick(1'b1, b);
            if (in_frame) started = 1'b1;
            else if (started) return;
        end
        check("backpressure frame timeout", 32'd1, 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while ((evq.size() > 0) && (evq[0].cyc < cyc)) begin
                check("missed chain event", 32'(evq[0].cyc), 32'(cyc));
                void'(evq.pop_front());
            end
            es = (evq.size() > 0) && !evq[0].is_latch && (evq[0].cyc == cyc);
            el = (evq.size() > 0) &&  evq[0].is_latch && (evq[0].cyc == cyc);
            if (cfg_shift_en || es) begin
                check("cfg_shift_en", cfg_shift_en, es);
                if (es && cfg_shift_en) check("cfg_data", cfg_data, evq[0].val);
                if (es) void'(evq.pop_front());
            end
            if (cfg_latch || el) begin
                check("cfg_latch", cfg_latch, el);
                if (el) void'(evq.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] tmp[$];
        logic [7:0] d;
        logic [7:0] c;

        rst = 1'b1;
        host.byte_valid = 1'b0;
        host.byte_in    = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        check("reset byte_ready", host.byte_ready, 1'b1);
        check("reset cfg_data", cfg_data, 1'b0);
        check("reset cfg_shift_en", cfg_shift_en, 1'b0);
        check("reset cfg_latch", cfg_latch, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset crc_err", crc_err, 1'b0);

        // good frame
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h1B);
        idle(4);
        // bad CRC
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h1C);
        idle(4);
        // garbage ahead of sync
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h1B);
        idle(4);
        // sync value as payload
        tmp = {8'hA5, 8'h00};
        send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h00); send_byte(ref_crc(tmp));
        idle(4);

        // reset on the 4th shift cycle of data byte 2, then a good frame
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        idle(3);
        reset_cycle();
        check("post-reset cfg_shift_en", cfg_shift_en, 1'b0);
        check("post-reset cfg_latch", cfg_latch, 1'b0);
        idle(2);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h1B);
        idle(4);

        // valid held high, byte changes every cycle
        bp_frame();
        bp_frame();
        idle(4);

        // random frames with gaps, leading garbage and occasional CRC corruption
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = 8'($urandom);
                if (d == SYNC) d = 8'h00;
                send_gap(d);
            end
            send_gap(SYNC);
            tmp.delete();
            for (int k = 0; k < NB; k++) begin
                d = 8'($urandom);
                tmp.push_back(d);
                send_gap(d);
            end
            c = ref_crc(tmp);
            if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
            send_gap(c);
            idle($urandom_range(0, 3));
        end

        idle(12);
        check("scoreboard drained", 32'(evq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
